// File: rtl/encoder_pkg.sv
// Shared constants and enums for the encoder permutation sequencer.
package encoder_pkg;

    localparam int LANE_W  = 25;
    localparam int LANES   = 64;
    localparam int STATE_W = LANES * LANE_W;
    localparam int ROUNDS  = 24;
    localparam int STAGES  = 5;

    typedef enum logic [2:0] {
        THETA,
        RHO,
        PI,
        CHI,
        IOTA
    } stage_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/encoder_round_ctrl_if.sv
// Job and stage-unit bundle between the sequencer and its neighbours.
interface encoder_round_ctrl_if #(
    parameter int STATE_W = encoder_pkg::STATE_W
);

    logic                 start;
    logic                 abort;
    logic [0:STATE_W-1]   pin;
    logic [0:STATE_W-1]   stage_in;
    logic [0:STATE_W-1]   state_q;
    logic [2:0]           stage;
    logic [4:0]           round;
    logic                 busy;
    logic                 done;
    logic [0:STATE_W-1]   pout;

    modport master (
        output start, abort, pin, stage_in,
        input  state_q, stage, round, busy, done, pout
    );

    modport slave (
        input  start, abort, pin, stage_in,
        output state_q, stage, round, busy, done, pout
    );

endinterface

// File: rtl/stage_round_counter.sv
// Stage/round position within a permutation job; clr wins over en.
module stage_round_counter #(
    parameter int ROUNDS = 24,
    parameter int STAGES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] stage,
    output logic [4:0] round,
    output logic       last
);

    localparam logic [2:0] STG_LAST = 3'(STAGES - 1);
    localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);

    logic [2:0] stage_q, stage_d;
    logic [4:0] round_q, round_d;

    assign last = (stage_q == STG_LAST) && (round_q == RND_LAST);

    // Round saturates at its last value; the controller clears on exit.
    always_comb begin
        stage_d = stage_q;
        round_d = round_q;
        if (clr) begin
            stage_d = '0;
            round_d = '0;
        end else if (en) begin
            if (stage_q == STG_LAST) begin
                stage_d = '0;
                round_d = last ? round_q : round_q + 5'd1;
            end else begin
                stage_d = stage_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            round_q <= '0;
        end else begin
            stage_q <= stage_d;
            round_q <= round_d;
        end
    end

    assign stage = stage_q;
    assign round = round_q;

endmodule

// File: rtl/encoder_round_ctrl.sv
// Round sequencer: steps the state register through ROUNDS x STAGES
// external combinational stage units and publishes the final state.
module encoder_round_ctrl
    import encoder_pkg::*;
#(
    parameter int ROUNDS  = encoder_pkg::ROUNDS,
    parameter int STAGES  = encoder_pkg::STAGES,
    parameter int STATE_W = encoder_pkg::STATE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    encoder_round_ctrl_if.slave   bus
);

    ctrl_state_e        fsm_q;
    logic [0:STATE_W-1] state_q;
    logic [0:STATE_W-1] pout_q;
    logic [2:0]         stage;
    logic [4:0]         round;
    logic               last;
    logic               cnt_en;
    logic               cnt_clr;

    assign cnt_en  = (fsm_q == RUN);
    assign cnt_clr = (fsm_q != RUN) || bus.abort || last;

    stage_round_counter #(
        .ROUNDS (ROUNDS),
        .STAGES (STAGES)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .stage (stage),
        .round (round),
        .last  (last)
    );

    // Abort freezes state_q and leaves pout untouched, even on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            pout_q  <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q <= bus.pin;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        fsm_q <= IDLE;
                    end else begin
                        state_q <= bus.stage_in;
                        if (last) begin
                            pout_q <= bus.stage_in;
                            fsm_q  <= DONE;
                        end
                    end
                end
                DONE: fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.state_q = state_q;
    assign bus.pout    = pout_q;
    assign bus.stage   = stage;
    assign bus.round   = round;
    assign bus.busy    = (fsm_q == RUN) || (fsm_q == DONE);
    assign bus.done    = (fsm_q == DONE);

endmodule

// File: tb/tb_encoder_round_ctrl.sv
// Bench for encoder_round_ctrl with a position-dependent adder stub.
module tb_encoder_round_ctrl;

    localparam int W = 1600;
    localparam int R = 24;
    localparam int N = R * 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [0:W-1] pout_ref;
    logic [0:W-1] state_ref;

    encoder_round_ctrl_if #(.STATE_W(W)) bus ();

    encoder_round_ctrl #(
        .ROUNDS  (R),
        .STAGES  (5),
        .STATE_W (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stub stage unit: adds (round*8 + stage + 1) to the state.
    assign bus.stage_in = bus.state_q + W'({bus.round, bus.stage}) + W'(1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [0:W-1] obs,
                         input logic [0:W-1] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed ..%h expected ..%h", tag,
                   obs[W-96:W-1], exp[W-96:W-1]);
        end
    endtask

    function automatic logic [0:W-1] rand_state();
        logic [0:W-1] s;
        s = '0;
        for (int i = 0; i < W / 32; i++)
            s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // State after n stage steps: step k adds round*8 + stage + 1.
    function automatic logic [0:W-1] partial(input logic [0:W-1] p,
                                             input int n);
        logic [0:W-1] s;
        s = p;
        for (int k = 0; k < n; k++)
            s = s + W'((k / 5) * 8 + (k % 5) + 1);
        return s;
    endfunction

    task automatic run_job(input logic [0:W-1] p, input int dup_at,
                           input int abort_at);
        int           end_c;
        int           busy_n;
        int           done_n;
        logic         ok;
        logic         run;
        logic [0:W-1] pold;
        ok     = (abort_at == 0) || (abort_at > N);
        end_c  = ok ? N + 2 : abort_at + 2;
        pold   = pout_ref;
        busy_n = 0;
        done_n = 0;
        bus.pin   = p;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.pin   = rand_state();
        for (int c = 1; c < end_c; c++) begin
            run = (c <= N) && (ok || c <= abort_at);
            chk_n("stage", int'(bus.stage), run ? (c - 1) % 5 : 0);
            chk_n("round", int'(bus.round), run ? (c - 1) / 5 : 0);
            chk_n("busy", int'(bus.busy), int'(run || (ok && c == N + 1)));
            chk_n("done", int'(bus.done), int'(ok && c == N + 1));
            chk_w("pout", bus.pout, (ok && c > N) ? partial(p, N) : pold);
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            bus.start = (c == dup_at);
            if (c == dup_at) bus.pin = ~p;
            bus.abort = (c == abort_at);
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_n("busy_len", busy_n, ok ? N + 1 : abort_at);
        chk_n("done_cnt", done_n, int'(ok));
        state_ref = partial(p, ok ? N : abort_at - 1);
        chk_w("state_end", bus.state_q, state_ref);
        chk_n("idle_busy", int'(bus.busy), 0);
        if (ok) pout_ref = partial(p, N);
    endtask

    task automatic chk_zero(input string tag);
        chk_w({tag, "_state"}, bus.state_q, '0);
        chk_w({tag, "_pout"}, bus.pout, '0);
        chk_n({tag, "_stage"}, int'(bus.stage), 0);
        chk_n({tag, "_round"}, int'(bus.round), 0);
        chk_n({tag, "_busy"}, int'(bus.busy), 0);
        chk_n({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        logic [0:W-1] p;
        int           ab;
        checks    = 0;
        errors    = 0;
        pout_ref  = '0;
        state_ref = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pin   = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        run_job('0, 0, 0);
        run_job(rand_state(), 10, 0);
        run_job(rand_state(), 0, 50);
        run_job(rand_state(), 0, 0);
        run_job(rand_state(), 0, N);

        // start together with abort in IDLE must not launch a job
        bus.pin   = rand_state();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_n("sa_busy", int'(bus.busy), 0);
        chk_n("sa_stage", int'(bus.stage), 0);
        chk_w("sa_state", bus.state_q, state_ref);
        tick();
        chk_n("sa_busy2", int'(bus.busy), 0);
        chk_w("sa_pout", bus.pout, pout_ref);

        // reset in the middle of a job
        bus.pin   = rand_state();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (59) tick();
        chk_n("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        pout_ref = '0;
        tick();
        chk_n("post_rst_busy", int'(bus.busy), 0);

        for (int j = 0; j < 4; j++) begin
            p  = rand_state();
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N)) : 0;
            run_job(p, int'($urandom_range(1, 40)), ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/encoder_round_ctrl.md
# encoder_round_ctrl

Round sequencer for the 1600-bit encoder permutation datapath. Accepts a 1600-bit state (64 lanes × 25 bits, big-endian bit order `[0:1599]`) and holds it in a state register. It then steps the register through ROUNDS rounds of five stages: theta, rho, pi, chi, iota. The stage units are external and combinational: each cycle this block selects one of them, drives it from `state_q`, and captures its result. It sits between the state reader/loader and the permute-output writer, and is their only sequencing authority.

## Interface
Parameters:
- `ROUNDS`, 24: permutation rounds per job; legal range 1..31.
- `STAGES`, 5: stages per round. Fixed; not overridable in practice.
- `STATE_W`, 1600: state width, equal to LANES × LANE_W (64 × 25).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request, sampled only in IDLE.
- `abort`, in, 1: cancel the current job.
- `pin`, in, [0:STATE_W-1]: initial state, captured in the cycle `start` is accepted.
- `stage_in`, in, [0:STATE_W-1]: result of the currently selected stage unit, computed from `state_q`.
- `state_q`, out, [0:STATE_W-1]: working state register; feeds all stage units.
- `stage`, out, 3: selected stage (0 theta, 1 rho, 2 pi, 3 chi, 4 iota). Valid in RUN only; 0 otherwise.
- `round`, out, 5: current round index, also the iota round-constant index. Valid in RUN; 0 otherwise.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `pout`, out, [0:STATE_W-1]: final permuted state, held until the next completed job.

## Operation
FSM states: IDLE, RUN, DONE.

- **IDLE:**
  - If `start` is high and `abort` is low: `state_q <= pin`, `stage <= 0`, `round <= 0`, go to RUN.
  - Otherwise hold.
- **RUN:**
  - Each cycle, `state_q <= stage_in`.
  - If `stage == 4`: `stage <= 0`, `round <= round + 1`. Otherwise `stage <= stage + 1`.
  - In the cycle with `round == ROUNDS-1` and `stage == 4`: `pout <= stage_in`, go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then unconditionally go to IDLE.
- **abort:**
  - In RUN or DONE: next state is IDLE, `stage` and `round` clear to 0, `pout` is unchanged, `state_q` holds its value.
  - An abort in the final RUN cycle has priority: `pout` is not written and `done` does not pulse.
  - In IDLE, `abort` suppresses `start`.
- **start while busy:** ignored, not queued.
- **rst:** `state_q`, `pout`, `stage` and `round` reset to 0; FSM goes to IDLE; `busy` and `done` reset to 0. Reset has priority over everything, including in the middle of a job.
- **Counter widths:** `stage` is 3 bits and never exceeds 4. `round` is 5 bits and never exceeds ROUNDS-1; there is no wrap.

## Timing
- The start edge is T0 (`start` sampled high in IDLE). RUN occupies cycles T0+1 through T0+ROUNDS×5; that is 120 cycles at the defaults.
- `done` is high in cycle T0+121. `pout` is valid from that same cycle.
- `busy` rises in T0+1 and falls after the DONE cycle. The earliest next `start` is accepted in cycle T0+122.
- `stage` and `round` are registered; the external stage units see stable selects for a whole cycle.
- The combinational path is `state_q` → stage unit → `stage_in` → `state_q`, single cycle. No pipelining is inside this block.
- All outputs are registered except `done` and `busy`, which are decoded from the FSM state register.

## Structure
- Shared package `encoder_pkg` holds:
  - constants `LANE_W = 25`, `LANES = 64`, `STATE_W = 1600`, `ROUNDS = 24`;
  - enum `stage_e` (THETA, RHO, PI, CHI, IOTA);
  - enum `ctrl_state_e` (IDLE, RUN, DONE).
- Sub-module `stage_round_counter` holds the `stage`/`round` pair. Its ports are `clk`, `rst`, `clr`, `en`, `stage`, `round` and a `last` flag (`round == ROUNDS-1 && stage == 4`).
- FSM, state register and output register live in the top module.

## Test plan
- **Nominal job:** reset, then `pin` = all-zeros and `start` for 1 cycle, with a stub where `stage_in = state_q + 1` (lane-0 increment). Required: `done` in cycle T0+121, `pout` lane 0 = 120, `busy` high for exactly 121 cycles.
- **Sequence check:** monitor `stage`/`round` during RUN. Required: the order 0,1,2,3,4 repeats; `round` increments only after `stage` 4; final values are `round` = 23, `stage` = 4; both are 0 in IDLE.
- **start while busy:** assert `start` at T0+10 with a different `pin`. Required: it is ignored; `pout` matches the first job; a single `done`.
- **Abort mid-run:** assert `abort` at T0+50. Required: IDLE at T0+51, `busy` = 0, no `done`, `pout` keeps its previous value; a new `start` at T0+52 completes normally.
- **Abort on final cycle:** assert `abort` at T0+120. Required: no `done`, `pout` unchanged. Also assert `abort` together with `start` in IDLE. Required: it stays in IDLE.
- **Reset mid-operation:** assert `rst` at T0+60. Required: all outputs are 0 in the next cycle, and the FSM is in IDLE.
